iobus_arb: RTL and testbench

Two-master arbiter for the shared 16-bit peripheral register bus. It lets the j1 I/O port and the JTAG debug master share one set of peripheral registers (status display, buttons, VGA control). Requests are granted round-robin. Each granted access is sequenced as a single strobe followed by a ready wait, and a timeout guards against a peripheral that never answers. It sits between the CPU/debug masters and the board-level peripheral address decode.

---
 rtl/iobus_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 31 +++
 rtl/iobus_arb.sv | 151 +++++++++++++++
 tb/tb_iobus_arb.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iobus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iobus_pkg
// Description : Shared constants and state encoding for the 16-bit peripheral
//               register bus. Future bus peripherals reuse these definitions.
// Revision    : 1.0 - initial release
// ============================================================================
package iobus_pkg;

    localparam int IOB_AW = 16;   // bus address width
    localparam int IOB_DW = 16;   // bus data width

    // Access sequencer states
    typedef enum logic [1:0] {
        IOB_IDLE  = 2'd0,
        IOB_ISSUE = 2'd1,
        IOB_WAIT  = 2'd2,
        IOB_DONE  = 2'd3
    } iob_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin pick. Purely combinational; the caller
//               owns the last_grant history register.
// Ports       : req[1:0]   - request vector (bit i = master i)
//               last_grant - index of the most recently served master
//               grant      - index of the selected master
//               valid      - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    // A single requester wins outright; on a tie the master that was not
    // served last goes next.
    always_comb begin
        grant = req[1];
        if (req == 2'b11) begin
            grant = ~last_grant;
        end
    end

    assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/iobus_arb.sv
`default_nettype none
// ============================================================================
// Module      : iobus_arb
// Description : Two-master round-robin arbiter for the shared peripheral
//               register bus (m0 = j1 I/O port, m1 = JTAG debug master).
//               Each grant issues one strobe, waits for s_ready and guards
//               the wait with a timeout that returns ERR_DATA.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               m*_req/we/addr/wdata  - master request side
//               m*_ack/rdata          - master completion side
//               s_addr/wdata/re/we    - peripheral access (registered)
//               s_rdata/s_ready       - peripheral response
//               busy                  - sequencer not idle
//               timeout_err           - sticky timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module iobus_arb
    import iobus_pkg::*;
#(
    parameter int unsigned        TIMEOUT  = 255,
    parameter logic [IOB_DW-1:0]  ERR_DATA = 16'hDEAD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [IOB_AW-1:0] m0_addr,
    input  logic [IOB_DW-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [IOB_DW-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [IOB_AW-1:0] m1_addr,
    input  logic [IOB_DW-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [IOB_DW-1:0] m1_rdata,
    output logic [IOB_AW-1:0] s_addr,
    output logic [IOB_DW-1:0] s_wdata,
    output logic              s_re,
    output logic              s_we,
    input  logic [IOB_DW-1:0] s_rdata,
    input  logic              s_ready,
    output logic              busy,
    output logic              timeout_err
);

    localparam logic [7:0] c_TIMEOUT = TIMEOUT[7:0];

    iob_state_t        r_state;
    logic              r_grant;
    logic              r_last_grant;
    logic [7:0]        r_cnt;

    logic              w_grant;
    logic              w_valid;
    logic              w_tmo;
    logic              w_fin;
    logic [IOB_DW-1:0] w_fin_data;

    rr_arb2 u_rr_arb2 (
        .req        ({m1_req, m0_req}),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .valid      (w_valid)
    );

    // s_ready is honoured in ISSUE as well as WAIT; the timeout only fires in
    // WAIT and loses to a simultaneous s_ready.
    assign w_tmo      = (r_state == IOB_WAIT) && !s_ready && (r_cnt == 8'd0);
    assign w_fin      = ((r_state == IOB_ISSUE) || (r_state == IOB_WAIT)) &&
                        (s_ready || w_tmo);
    assign w_fin_data = s_ready ? s_rdata : ERR_DATA;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IOB_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= 8'd0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
            s_addr       <= '0;
            s_wdata      <= '0;
            s_re         <= 1'b0;
            s_we         <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            // Strobes and acks are single-cycle pulses.
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            s_re   <= 1'b0;
            s_we   <= 1'b0;

            case (r_state)
                IOB_IDLE: begin
                    if (w_valid) begin
                        r_grant <= w_grant;
                        s_addr  <= w_grant ? m1_addr  : m0_addr;
                        s_wdata <= w_grant ? m1_wdata : m0_wdata;
                        s_we    <= w_grant ? m1_we    : m0_we;
                        s_re    <= w_grant ? ~m1_we   : ~m0_we;
                        // Counter holds TIMEOUT during ISSUE and reaches 0
                        // in the last WAIT cycle, TIMEOUT cycles after the
                        // strobe.
                        r_cnt   <= c_TIMEOUT;
                        busy    <= 1'b1;
                        r_state <= IOB_ISSUE;
                    end
                end

                IOB_ISSUE, IOB_WAIT: begin
                    if (w_fin) begin
                        if (r_grant) begin
                            m1_ack   <= 1'b1;
                            m1_rdata <= w_fin_data;
                        end else begin
                            m0_ack   <= 1'b1;
                            m0_rdata <= w_fin_data;
                        end
                        if (w_tmo) begin
                            timeout_err <= 1'b1;
                        end
                        r_state <= IOB_DONE;
                    end else begin
                        // Saturate so TIMEOUT = 0 still times out.
                        if (r_cnt != 8'd0) begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                        r_state <= IOB_WAIT;
                    end
                end

                IOB_DONE: begin
                    r_last_grant <= r_grant;
                    busy         <= 1'b0;
                    r_state      <= IOB_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    r_state <= IOB_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iobus_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_iobus_arb
// Description : Scoreboard bench for iobus_arb. Stimulus pushes expected
//               strobes and acks into queues; monitors pop and compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iobus_arb;

    localparam int TO = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [15:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic        m0_ack, m1_ack;
    logic [15:0] m0_rdata, m1_rdata;
    logic [15:0] s_addr, s_wdata;
    logic        s_re, s_we;
    logic [15:0] s_rdata = '0;
    logic        s_ready = 1'b0;
    logic        busy, timeout_err;

    iobus_arb #(.TIMEOUT(TO), .ERR_DATA(16'hDEAD)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_re(s_re), .s_we(s_we),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {int m; logic [15:0] data; int cyc;} ack_t;
    typedef struct {logic we; logic [15:0] addr; logic [15:0] wdata; int cyc;} stb_t;
    ack_t ackq[$];
    stb_t stbq[$];

    // Peripheral model: raise s_ready for one cycle rdy_delay cycles after
    // the strobe (0 = during the strobe cycle, negative = never).
    int          rdy_delay = 0;
    logic [15:0] prd = '0;
    int          pk = 0;
    bit          pend = 0;
    always begin
        @(posedge clk);
        #1;
        if (s_re || s_we) begin
            pend = 1;
            pk   = 0;
        end else if (pend) begin
            pk++;
        end
        s_ready = pend && (rdy_delay >= 0) && (pk == rdy_delay);
        s_rdata = prd;
        if (s_ready) pend = 0;
    end

    // Strobe and ack monitors.
    always @(negedge clk) begin
        if (!reset) begin
            if (s_re || s_we) begin : strobe_chk
                stb_t e;
                check("strobe_excl", 32'(s_re && s_we), 0);
                if (stbq.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    e = stbq.pop_front();
                    check("strobe_we", 32'(s_we), 32'(e.we));
                    check("s_addr", 32'(s_addr), 32'(e.addr));
                    if (e.we) check("s_wdata", 32'(s_wdata), 32'(e.wdata));
                    check("strobe_cycle", cyc, e.cyc);
                end
            end
            if (m0_ack || m1_ack) begin : ack_chk
                ack_t e;
                check("ack_excl", 32'(m0_ack && m1_ack), 0);
                if (ackq.size() == 0) begin
                    check("unexpected_ack", 1, 0);
                end else begin
                    e = ackq.pop_front();
                    check("ack_master", m1_ack ? 1 : 0, e.m);
                    check("ack_rdata", 32'(m1_ack ? m1_rdata : m0_rdata), 32'(e.data));
                    check("ack_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input bit req, input bit we,
                         input logic [15:0] a, input logic [15:0] d);
        if (m == 0) begin
            m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
        end
    endtask

    task automatic wait_ack(input int m);
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if ((m == 0) ? m0_ack : m1_ack) got = 1;
        end
        if (!got) check("ack_wait_expired", 0, 1);
    endtask

    // One isolated access issued while the arbiter is idle.
    task automatic txn(input int m, input bit we, input logic [15:0] a,
                       input logic [15:0] d, input int delay, input logic [15:0] rd);
        int c;
        bit tmo;
        rdy_delay = delay;
        prd       = rd;
        set_m(m, 1, we, a, d);
        c   = cyc;
        tmo = (delay < 0) || (delay > TO);
        stbq.push_back('{we, a, d, c + 1});
        ackq.push_back('{m, tmo ? 16'hDEAD : rd, tmo ? c + 2 + TO : c + 2 + delay});
        wait_ack(m);
        tick();
        set_m(m, 0, 0, 16'h0, 16'h0);
        tick();
    endtask

    initial begin : stim
        int c;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_acks", 32'({m0_ack, m1_ack}), 0);
        check("rst_strobes", 32'({s_re, s_we}), 0);
        check("rst_s_addr", 32'(s_addr), 0);
        check("rst_s_wdata", 32'(s_wdata), 0);
        check("rst_rdata", 32'({m0_rdata, m1_rdata}), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        tick();

        // Both masters request together straight after reset: m0, m1, m0, m1.
        rdy_delay = 0;
        prd       = 16'h0A5A;
        c = cyc;
        stbq.push_back('{1'b0, 16'h0010, 16'h0000, c + 1});
        ackq.push_back('{0, 16'h0A5A, c + 2});
        stbq.push_back('{1'b1, 16'h0020, 16'h1111, c + 4});
        ackq.push_back('{1, 16'h0A5A, c + 5});
        stbq.push_back('{1'b0, 16'h0030, 16'h0000, c + 7});
        ackq.push_back('{0, 16'h0A5A, c + 8});
        stbq.push_back('{1'b1, 16'h0040, 16'h2222, c + 10});
        ackq.push_back('{1, 16'h0A5A, c + 11});
        for (int t = 0; t < 14; t++) begin
            case (t)
                0: begin
                    set_m(0, 1, 0, 16'h0010, 16'h0000);
                    set_m(1, 1, 1, 16'h0020, 16'h1111);
                end
                3:  set_m(0, 0, 0, 16'h0, 16'h0);
                4:  set_m(0, 1, 0, 16'h0030, 16'h0000);
                6:  set_m(1, 0, 0, 16'h0, 16'h0);
                7:  set_m(1, 1, 1, 16'h0040, 16'h2222);
                9:  set_m(0, 0, 0, 16'h0, 16'h0);
                12: set_m(1, 0, 0, 16'h0, 16'h0);
                default: ;
            endcase
            tick();
        end

        // m0 read with s_ready during the strobe.
        txn(0, 0, 16'h8000, 16'h0000, 0, 16'h1234);
        check("m0_rdata_read", 32'(m0_rdata), 32'h1234);

        // m1 write, s_ready 5 cycles after the strobe.
        txn(1, 1, 16'h8000, 16'hBEEF, 5, 16'h5555);
        check("m1_rdata_write", 32'(m1_rdata), 32'h5555);
        check("m0_rdata_held", 32'(m0_rdata), 32'h1234);

        // m0 served last, so a tie now goes to m1.
        txn(0, 0, 16'h0050, 16'h0000, 0, 16'h7777);
        prd = 16'h6161;
        c = cyc;
        stbq.push_back('{1'b0, 16'h0070, 16'h0000, c + 1});
        ackq.push_back('{1, 16'h6161, c + 2});
        stbq.push_back('{1'b0, 16'h0060, 16'h0000, c + 4});
        ackq.push_back('{0, 16'h6161, c + 5});
        for (int t = 0; t < 8; t++) begin
            case (t)
                0: begin
                    set_m(0, 1, 0, 16'h0060, 16'h0000);
                    set_m(1, 1, 0, 16'h0070, 16'h0000);
                end
                3:  set_m(1, 0, 0, 16'h0, 16'h0);
                6:  set_m(0, 0, 0, 16'h0, 16'h0);
                default: ;
            endcase
            tick();
        end

        // s_ready in the very cycle the counter hits zero: real data wins.
        txn(0, 0, 16'h0200, 16'h0000, TO, 16'h3C3C);
        check("boundary_no_tmo", 32'(timeout_err), 0);

        // Peripheral never answers: ERR_DATA and sticky flag.
        txn(0, 0, 16'h0100, 16'h0000, -1, 16'h0000);
        check("timeout_err_set", 32'(timeout_err), 1);
        txn(1, 0, 16'h0101, 16'h0000, 0, 16'h4242);
        check("timeout_err_sticky", 32'(timeout_err), 1);

        // Reset while waiting: no ack, everything back to reset values.
        rdy_delay = -1;
        set_m(0, 1, 0, 16'h0300, 16'h0000);
        c = cyc;
        stbq.push_back('{1'b0, 16'h0300, 16'h0000, c + 1});
        repeat (3) tick();
        reset = 1'b1;
        set_m(0, 0, 0, 16'h0, 16'h0);
        tick();
        @(negedge clk);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_acks", 32'({m0_ack, m1_ack}), 0);
        check("midrst_strobes", 32'({s_re, s_we}), 0);
        check("midrst_s_addr", 32'(s_addr), 0);
        check("midrst_rdata", 32'({m0_rdata, m1_rdata}), 0);
        check("midrst_timeout_err", 32'(timeout_err), 0);
        tick();
        reset = 1'b0;
        repeat (2) tick();
        txn(1, 0, 16'h0400, 16'h0000, 2, 16'h9999);
        check("post_rst_m1_rdata", 32'(m1_rdata), 32'h9999);

        repeat (4) tick();
        check("ackq_drained", ackq.size(), 0);
        check("stbq_drained", stbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
